// File: rtl/rx_uart_cfg_pkg.sv
// Shared definitions for the rx_uart_cfg receiver: FSM state encoding and counter sizing.
// The PARITY state exists only when RX_UART_CFG_PARITY_EN is defined.
package rx_uart_cfg_pkg;

  localparam int NB_STATE = 3;

  typedef enum logic [NB_STATE-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef RX_UART_CFG_PARITY_EN
    ,
    ST_PARITY = 3'd4
`endif
  } state_t;

  // Bits needed for a counter running 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rx_uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; flops reset to RST_VAL.
module rx_uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta_p0;
  logic sync_p1;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      meta_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      meta_p0 <= i_d;
      sync_p1 <= meta_p0;
    end
  end

  assign o_q = sync_p1;

endmodule

// File: rtl/rx_uart_cfg.sv
// Oversampling UART receiver with framing check; optional parity check when
// RX_UART_CFG_PARITY_EN is defined (adds i_parity_odd and the PARITY state).
module rx_uart_cfg
  import rx_uart_cfg_pkg::*;
#(
  parameter int NB_DATA    = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_s_tick,
  input  logic               i_rx,
`ifdef RX_UART_CFG_PARITY_EN
  input  logic               i_parity_odd,
`endif
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done_tick,
  output logic               o_frame_err,
  output logic               o_parity_err,
  output logic               o_busy
);

  localparam int TICK_MAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
  localparam int NB_TICK  = cnt_w(TICK_MAX);
  localparam int NB_BIT   = cnt_w(NB_DATA);

  localparam logic [NB_TICK-1:0] TICK_MID  = NB_TICK'(OVERSAMPLE / 2 - 1);
  localparam logic [NB_TICK-1:0] TICK_BIT  = NB_TICK'(OVERSAMPLE - 1);
  localparam logic [NB_TICK-1:0] TICK_STOP = NB_TICK'(SB_TICK - 1);
  localparam logic [NB_BIT-1:0]  BIT_LAST  = NB_BIT'(NB_DATA - 1);

`ifdef RX_UART_CFG_PARITY_EN
  localparam state_t ST_AFTER_DATA = ST_PARITY;
`else
  localparam state_t ST_AFTER_DATA = ST_STOP;
`endif

  state_t               state;
  logic [NB_TICK-1:0]   tick_cnt;
  logic [NB_BIT-1:0]    bit_cnt;
  logic [NB_DATA-1:0]   shreg;
  logic                 stop_bit;
  logic                 armed;
  logic                 rx_s;
  logic                 at_bit;
  logic                 stop_sample;
`ifdef RX_UART_CFG_PARITY_EN
  logic                 par_err;
`endif

  rx_uart_sync #(
    .RST_VAL (1'b1)
  ) u_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  assign at_bit      = (tick_cnt == TICK_BIT);
  // Framing sample may coincide with completion when SB_TICK equals OVERSAMPLE.
  assign stop_sample = at_bit ? rx_s : stop_bit;
  assign o_busy      = (state != ST_IDLE);

  // armed blocks a held-low line (break) from being taken as a new start bit.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state          <= ST_IDLE;
      tick_cnt       <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      stop_bit       <= 1'b1;
      armed          <= 1'b1;
      o_data         <= '0;
      o_frame_err    <= 1'b0;
      o_rx_done_tick <= 1'b0;
`ifdef RX_UART_CFG_PARITY_EN
      par_err        <= 1'b0;
      o_parity_err   <= 1'b0;
`endif
    end else begin
      o_rx_done_tick <= 1'b0;
      if (rx_s) armed <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (!rx_s && armed) begin
            state    <= ST_START;
            tick_cnt <= '0;
          end
        end
        ST_START: begin
          if (i_s_tick) begin
            if (tick_cnt == TICK_MID) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rx_s ? ST_IDLE : ST_DATA;
            end else begin
              tick_cnt <= tick_cnt + NB_TICK'(1);
            end
          end
        end
        ST_DATA: begin
          if (i_s_tick) begin
            if (at_bit) begin
              tick_cnt <= '0;
              shreg    <= {rx_s, shreg[NB_DATA-1:1]};
              if (bit_cnt == BIT_LAST) state <= ST_AFTER_DATA;
              else bit_cnt <= bit_cnt + NB_BIT'(1);
            end else begin
              tick_cnt <= tick_cnt + NB_TICK'(1);
            end
          end
        end
`ifdef RX_UART_CFG_PARITY_EN
        ST_PARITY: begin
          if (i_s_tick) begin
            if (at_bit) begin
              tick_cnt <= '0;
              par_err  <= ((^shreg) ^ rx_s) != i_parity_odd;
              state    <= ST_STOP;
            end else begin
              tick_cnt <= tick_cnt + NB_TICK'(1);
            end
          end
        end
`endif
        ST_STOP: begin
          if (i_s_tick) begin
            if (at_bit) stop_bit <= rx_s;
            if (tick_cnt == TICK_STOP) begin
              state          <= ST_IDLE;
              tick_cnt       <= '0;
              o_data         <= shreg;
              o_frame_err    <= ~stop_sample;
              o_rx_done_tick <= 1'b1;
`ifdef RX_UART_CFG_PARITY_EN
              o_parity_err   <= par_err;
`endif
              if (!stop_sample) armed <= 1'b0;
            end else begin
              tick_cnt <= tick_cnt + NB_TICK'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef RX_UART_CFG_PARITY_EN
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_uart_cfg.sv
// Scoreboard bench for rx_uart_cfg: an 8-bit/1-stop instance and a 5-bit/2-stop instance
// fed by a shared tick generator; expected words come from a frame-level reference model.
`timescale 1ns/1ps
module tb_rx_uart_cfg;

`ifdef RX_UART_CFG_PARITY_EN
  localparam int PAR_ON = 1;
`else
  localparam int PAR_ON = 0;
`endif

  typedef struct packed {
    logic [8:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_tick;
  logic       rx_line [2];
  logic       parity_odd;
  logic [7:0] data8;
  logic       done8, fe8, pe8, busy8;
  logic [4:0] data5;
  logic       done5, fe5, pe5, busy5;

  int   n_vec = 0;
  int   n_err = 0;
  int   tick_div;
  int   tick_cnt;
  logic [8:0] last8;
  exp_t q8[$];
  exp_t q5[$];

  always #5 clk = ~clk;

  rx_uart_cfg #(.NB_DATA(8), .OVERSAMPLE(16), .SB_TICK(16)) u_dut8 (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_s_tick       (s_tick),
    .i_rx           (rx_line[0]),
`ifdef RX_UART_CFG_PARITY_EN
    .i_parity_odd   (parity_odd),
`endif
    .o_data         (data8),
    .o_rx_done_tick (done8),
    .o_frame_err    (fe8),
    .o_parity_err   (pe8),
    .o_busy         (busy8)
  );

  rx_uart_cfg #(.NB_DATA(5), .OVERSAMPLE(16), .SB_TICK(32)) u_dut5 (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_s_tick       (s_tick),
    .i_rx           (rx_line[1]),
`ifdef RX_UART_CFG_PARITY_EN
    .i_parity_odd   (parity_odd),
`endif
    .o_data         (data5),
    .o_rx_done_tick (done5),
    .o_frame_err    (fe5),
    .o_parity_err   (pe5),
    .o_busy         (busy5)
  );

  // Baud-tick generator: one-cycle strobe every tick_div clocks, driven off the falling edge.
  initial begin
    s_tick   = 1'b0;
    tick_cnt = 0;
    forever begin
      @(negedge clk);
      tick_cnt++;
      if (tick_cnt >= tick_div) begin
        tick_cnt = 0;
        s_tick   = 1'b1;
      end else begin
        s_tick = 1'b0;
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Frame-level reference: word = data bits masked to width, frame error = stop level low,
  // parity error = total count of ones (data + parity bit) has the wrong oddness.
  function automatic exp_t model(input int nb, input logic [8:0] d, input logic par_bit,
                                 input logic odd, input logic stop_lvl);
    exp_t       e;
    logic [8:0] dm;
    dm   = d & 9'((1 << nb) - 1);
    e.d  = dm;
    e.fe = !stop_lvl;
    e.pe = (PAR_ON == 1) && ((($countones(dm) + int'(par_bit)) % 2) != int'(odd));
    return e;
  endfunction

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!s_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic drive(input int idx, input logic lvl);
    if (idx == 0) rx_line[0] = lvl;
    else rx_line[1] = lvl;
  endtask

  task automatic send_frame(input int idx, input int nb, input logic [8:0] d,
                            input logic par_bit, input logic stop_lvl, input int stop_ticks);
    exp_t e;
    e = model(nb, d, par_bit, parity_odd, stop_lvl);
    if (idx == 0) begin
      q8.push_back(e);
      last8 = e.d;
    end else begin
      q5.push_back(e);
    end
    drive(idx, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < nb; i++) begin
      drive(idx, d[i]);
      wait_ticks(16);
    end
    if (PAR_ON == 1) begin
      drive(idx, par_bit);
      wait_ticks(16);
    end
    drive(idx, stop_lvl);
    wait_ticks(stop_ticks);
    drive(idx, 1'b1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      if (q8.size() == 0) begin
        cmp("unexpected_done8", 32'd1, 32'd0);
      end else begin
        e = q8.pop_front();
        cmp("data8", 32'(data8), 32'(e.d));
        cmp("ferr8", 32'(fe8), 32'(e.fe));
        cmp("perr8", 32'(pe8), 32'(e.pe));
      end
    end
    if (done5) begin
      if (q5.size() == 0) begin
        cmp("unexpected_done5", 32'd1, 32'd0);
      end else begin
        e = q5.pop_front();
        cmp("data5", 32'(data5), 32'(e.d));
        cmp("ferr5", 32'(fe5), 32'(e.fe));
        cmp("perr5", 32'(pe5), 32'(e.pe));
      end
    end
  end

  initial begin
    logic [8:0] d;
    logic       stop_lvl;
    int         gap;

    rst        = 1'b1;
    rx_line[0] = 1'b1;
    rx_line[1] = 1'b1;
    parity_odd = 1'b0;
    tick_div   = 163;
    last8      = '0;
    repeat (5) @(negedge clk);
    cmp("rst_data8", 32'(data8), 32'd0);
    cmp("rst_done8", 32'(done8), 32'd0);
    cmp("rst_ferr8", 32'(fe8), 32'd0);
    cmp("rst_perr8", 32'(pe8), 32'd0);
    cmp("rst_busy8", 32'(busy8), 32'd0);
    cmp("rst_data5", 32'(data5), 32'd0);
    cmp("rst_busy5", 32'(busy5), 32'd0);
    rst = 1'b0;
    wait_ticks(2);

    // Slow baud: one frame at a tick every 163 clocks.
    send_frame(0, 8, 9'h07D, ^8'h7D, 1'b1, 16);
    wait_ticks(4);
    tick_div = 4;
    wait_ticks(4);

    // Odd parity on 0x81: correct parity bit, then a wrong one.
    parity_odd = 1'b1;
    send_frame(0, 8, 9'h081, 1'b1, 1'b1, 16);
    wait_ticks(2);
    send_frame(0, 8, 9'h081, 1'b0, 1'b1, 16);
    wait_ticks(4);

    // Start glitch of 4 ticks must be rejected without a strobe.
    rx_line[0] = 1'b0;
    wait_ticks(2);
    cmp("glitch_busy", 32'(busy8), 32'd1);
    wait_ticks(2);
    rx_line[0] = 1'b1;
    wait_ticks(16);
    cmp("glitch_idle", 32'(busy8), 32'd0);
    cmp("glitch_data", 32'(data8), 32'(last8));

    // Bad stop bit, then a clean 0x55.
    parity_odd = 1'b0;
    send_frame(0, 8, 9'h0A5, 1'b0, 1'b0, 16);
    wait_ticks(4);
    send_frame(0, 8, 9'h055, 1'b0, 1'b1, 16);
    wait_ticks(4);

    // Reset in the middle of data bit 3.
    rx_line[0] = 1'b0;
    wait_ticks(16);
    d = 9'h03C;
    for (int i = 0; i < 3; i++) begin
      rx_line[0] = d[i];
      wait_ticks(16);
    end
    rx_line[0] = d[3];
    wait_ticks(8);
    @(negedge clk);
    rst        = 1'b1;
    rx_line[0] = 1'b1;
    @(negedge clk);
    cmp("midrst_data8", 32'(data8), 32'd0);
    cmp("midrst_ferr8", 32'(fe8), 32'd0);
    cmp("midrst_perr8", 32'(pe8), 32'd0);
    cmp("midrst_busy8", 32'(busy8), 32'd0);
    cmp("midrst_done8", 32'(done8), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_ticks(4);
    send_frame(0, 8, 9'h0C3, ^8'hC3, 1'b1, 16);
    wait_ticks(4);

    // Break: line low from the start bit through stop and beyond.
    q8.push_back(model(8, 9'h000, 1'b0, parity_odd, 1'b0));
    last8      = '0;
    rx_line[0] = 1'b0;
    wait_ticks(16 * (10 + PAR_ON) + 32);
    cmp("break_no_restart", 32'(busy8), 32'd0);
    rx_line[0] = 1'b1;
    wait_ticks(8);
    send_frame(0, 8, 9'h05A, ^8'h5A, 1'b1, 16);
    wait_ticks(2);

    // Randomized 8-bit frames with occasional bad stop bits and short or no gaps.
    for (int n = 0; n < 12; n++) begin
      d          = 9'($urandom_range(0, 255));
      parity_odd = 1'($urandom_range(0, 1));
      stop_lvl   = ($urandom_range(0, 7) != 0);
      gap        = stop_lvl ? $urandom_range(0, 2) : 2 + $urandom_range(0, 2);
      send_frame(0, 8, d, 1'($urandom_range(0, 1)), stop_lvl, 16);
      wait_ticks(gap);
    end

    // 5-bit, two stop bits, back-to-back frames.
    parity_odd = 1'b0;
    send_frame(1, 5, 9'h015, 1'b1, 1'b1, 32);
    send_frame(1, 5, 9'h00A, 1'b0, 1'b1, 32);
    for (int n = 0; n < 8; n++) begin
      parity_odd = 1'($urandom_range(0, 1));
      send_frame(1, 5, 9'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b1, 32);
    end

    wait_ticks(40);
    cmp("pending8", 32'(q8.size()), 32'd0);
    cmp("pending5", 32'(q5.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
